// File: rtl/tcdm_stream_initiator.sv
// tcdm_stream_initiator
// Standalone TCDM master. It issues a programmed stream of strided single-word
// writes or reads, with a bounded number of outstanding requests. Write passes
// store seed+i into element i. Read passes check each response against seed+k,
// count the mismatches and accumulate a sum of the read data.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              soft clear, honoured only while not busy
//   start_i              start pulse, sampled in IDLE/DONE
//   base_addr_i, stride_i, len_i, write_i, seed_i   transfer programming
//   busy_o, done_o       status: busy while issuing/draining, done pulse
//   err_cnt_o, rd_sum_o  read-check results
//   proto_err_o          sticky: response seen with nothing outstanding
//   tcdm_*               req/gnt/r_valid initiator port
module tcdm_stream_initiator #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 32,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [AW-1:0]     base_addr_i,
    input  logic [AW-1:0]     stride_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              write_i,
    input  logic [DW-1:0]     seed_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LEN_W-1:0]  err_cnt_o,
    output logic [DW-1:0]     rd_sum_o,
    output logic              proto_err_o,
    output logic              tcdm_req_o,
    input  logic              tcdm_gnt_i,
    output logic [AW-1:0]     tcdm_add_o,
    output logic              tcdm_wen_o,
    output logic [DW/8-1:0]   tcdm_be_o,
    output logic [DW-1:0]     tcdm_data_o,
    input  logic              tcdm_r_valid_i,
    input  logic [DW-1:0]     tcdm_r_data_i
);

    localparam int unsigned OW = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     stride;
    logic [LEN_W-1:0]  len, idx, rsp_cnt;
    logic              write;
    logic [DW-1:0]     exp_data;
    logic [OW-1:0]     outst, outst_nxt;
    logic              fire, rsp, last_req, last_rsp;
    logic              idle_like, accept, clear_en, raise, done_set;

    assign fire     = tcdm_req_o & tcdm_gnt_i;
    // A response only counts when something is outstanding; otherwise it is
    // a protocol error and is dropped.
    assign rsp      = tcdm_r_valid_i & (outst != '0);
    assign last_req = ({1'b0, idx} + (LEN_W+1)'(1)) == {1'b0, len};
    assign last_rsp = ({1'b0, rsp_cnt} + (LEN_W+1)'(1)) == {1'b0, len};
    assign outst_nxt = outst + OW'(fire) - OW'(rsp);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (clear_i)      state_nxt = IDLE;
                else if (start_i) state_nxt = (len_i == '0) ? DONE : ISSUE;
            end
            ISSUE: if (fire && last_req) state_nxt = DRAIN;
            DRAIN: if (rsp && last_rsp)  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        idle_like = (state == IDLE) || (state == DONE);
        busy_o    = (state == ISSUE) || (state == DRAIN);
        clear_en  = idle_like & clear_i;
        accept    = idle_like & start_i & ~clear_i;
        // DONE->DONE happens only on a zero-length restart, which still pulses.
        done_set  = (state_nxt == DONE) & ((state != DONE) | accept);
        // An ungranted request is held; otherwise raise the next one only if
        // it exists and the outstanding count after this cycle leaves room.
        raise     = (state == ISSUE) &
                    ((tcdm_req_o & ~tcdm_gnt_i) |
                     (~(fire & last_req) & (outst_nxt < OW'(MAX_OUTST))));
    end

    // Datapath. The request registers double as the "next element" pointers:
    // address and data advance on each grant, so they are ready when req rises.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || clear_en) begin
            // The clear branch mirrors reset so both leave identical state.
            stride      <= '0;
            len         <= '0;
            write       <= 1'b0;
            exp_data    <= '0;
            idx         <= '0;
            rsp_cnt     <= '0;
            outst       <= '0;
            done_o      <= 1'b0;
            err_cnt_o   <= '0;
            rd_sum_o    <= '0;
            proto_err_o <= 1'b0;
            tcdm_req_o  <= 1'b0;
            tcdm_add_o  <= '0;
            tcdm_wen_o  <= 1'b0;
            tcdm_be_o   <= '0;
            tcdm_data_o <= '0;
        end else if (accept) begin
            stride      <= stride_i;
            len         <= len_i;
            write       <= write_i;
            exp_data    <= seed_i;
            idx         <= '0;
            rsp_cnt     <= '0;
            outst       <= '0;
            done_o      <= done_set;
            err_cnt_o   <= '0;
            rd_sum_o    <= '0;
            proto_err_o <= 1'b0;
            tcdm_req_o  <= (len_i != '0);
            tcdm_add_o  <= base_addr_i;
            tcdm_wen_o  <= ~write_i;
            tcdm_be_o   <= '1;
            tcdm_data_o <= write_i ? seed_i : '0;
        end else begin
            outst  <= outst_nxt;
            done_o <= done_set;
            if (tcdm_r_valid_i && outst == '0) proto_err_o <= 1'b1;
            if (rsp) begin
                rsp_cnt  <= rsp_cnt + 1'b1;
                exp_data <= exp_data + 1'b1;
                if (!write) begin
                    rd_sum_o <= rd_sum_o + tcdm_r_data_i;
                    if (tcdm_r_data_i != exp_data && err_cnt_o != '1)
                        err_cnt_o <= err_cnt_o + 1'b1;
                end
            end
            if (fire) begin
                idx        <= idx + 1'b1;
                tcdm_add_o <= tcdm_add_o + stride;
                if (write) tcdm_data_o <= tcdm_data_o + 1'b1;
            end
            tcdm_req_o <= raise;
        end
    end

endmodule
